fixed_coord_arbiter: RTL
========================

FIXED_COORD_ARBITER -- requirements
Module: fixed_coord_arbiter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320: screen width in pixels; X clamp bound is SCREEN_W-1.
REQ-002 SHALL have parameter SCREEN_H, default 240: screen height in pixels; Y clamp bound is SCREEN_H-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have ports in0_valid, in1_valid, input, 1 bit each: requester 0/1 holds a coordinate pair.
REQ-006 SHALL have ports in0_x, in0_y, in1_x, in1_y, input, 16 bits each: 1.8.7 fixed-point coordinates (bit15 sign, bits14:7 integer, bits6:0 fraction).
REQ-007 SHALL have ports in0_ready, in1_ready, output, 1 bit each: pair accepted this cycle.
REQ-008 SHALL have port out_valid, output, 1 bit: converted pair available.
REQ-009 SHALL have ports out_x, out_y, output, 16 bits each: unsigned pixel coordinates.
REQ-010 SHALL have port out_src, output, 1 bit: index of the requester that supplied the pair.
REQ-011 SHALL have port out_clamped, output, 1 bit: out_x or out_y was upper-clamped.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the pair.

Function
REQ-013 SHALL share one fixed-to-unsigned converter between both requesters and both coordinates, time-multiplexed by an FSM with states IDLE, CONV_X, CONV_Y, HOLD.
REQ-014 Conversion SHALL be: sign=1 -> 0; else bit6=1 -> integer+1 (9-bit result, 255.5 -> 256); else integer; zero-extended to 16 bits.
REQ-015 After conversion, a value above its bound SHALL be replaced by the bound and out_clamped set; a negative input mapped to 0 SHALL NOT set out_clamped.
REQ-016 In IDLE with any valid, the FSM SHALL grant one requester, assert only that requester's ready combinationally for that cycle, latch its x, y and index, and move to CONV_X.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-018 CONV_X SHALL convert the latched x into out_x and move to CONV_Y; CONV_Y SHALL convert the latched y into out_y and move to HOLD.
REQ-019 In HOLD, out_valid SHALL be 1 and out_x, out_y, out_src and out_clamped SHALL stay stable until out_ready=1; on that edge the FSM SHALL move to IDLE.
REQ-020 Latency SHALL be: accept on cycle N -> out_valid on cycle N+3; minimum spacing between accepts is 4 cycles.
REQ-021 in*_ready SHALL be 0 outside IDLE; out_ready SHALL be ignored outside HOLD; requesters hold valid and data until ready.
REQ-022 out_valid SHALL be 0 in IDLE, CONV_X and CONV_Y.

Reset
REQ-023 rst=1 SHALL immediately force: state IDLE, out_valid 0, out_x 0, out_y 0, out_src 0, out_clamped 0, last-grant pointer 1 (requester 0 wins the first tie).
REQ-024 Reset during CONV_X, CONV_Y or HOLD SHALL discard the pair in flight without emitting it.

Structure
REQ-025 Package gpu_fixed_pkg SHALL hold FIXED_W=16, INT_W=8, FRAC_W=7 and the FSM state enum.
REQ-026 The converter SHALL be one combinational sub-module, fixed_to_uint, instantiated once.

Verification
REQ-027 Only in0 valid, x=0x0540 (10.5), y=0x0520 (10.25), out_ready=1 -> in0_ready on cycle N; out_valid on cycle N+3 with out_x=11, out_y=10, out_src=0, out_clamped=0.
REQ-028 x=0x8000 (negative), y=0x7FC0 (255.5) -> out_x=0, out_y=239, out_clamped=1.
REQ-029 in0 and in1 both continuously valid after reset -> grants alternate 0,1,0,1 and out_src alternates accordingly.
REQ-030 out_ready held 0 for 5 cycles in HOLD -> out_valid stays 1 and outputs stay stable; no in*_ready asserted; on the first cycle with out_ready=1 the pair is consumed and the FSM returns to IDLE.
REQ-031 rst pulsed during CONV_Y -> all outputs 0 immediately, no out_valid for that pair, next tie goes to requester 0.

Source files
------------

// File: rtl/gpu_fixed_pkg.sv
// Shared widths and FSM encoding for the fixed-point coordinate pipeline.
package gpu_fixed_pkg;
  localparam int FIXED_W = 16;
  localparam int INT_W   = 8;
  localparam int FRAC_W  = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_X = 2'd1,
    CONV_Y = 2'd2,
    HOLD   = 2'd3
  } state_t;
endpackage

// File: rtl/fixed_to_uint.sv
// Combinational 1.8.7 fixed-point to unsigned pixel conversion with
// round-half-up on the first fraction bit; negative values map to 0.
module fixed_to_uint
  import gpu_fixed_pkg::*;
(
  input  logic [FIXED_W-1:0] fixed_in,
  output logic [FIXED_W-1:0] uint_out
);

  logic [INT_W:0] rounded;

  always_comb begin
    rounded = {1'b0, fixed_in[FIXED_W-2 -: INT_W]}
            + {{INT_W{1'b0}}, fixed_in[FRAC_W-1]};
    if (fixed_in[FIXED_W-1])
      uint_out = '0;
    else
      uint_out = {{(FIXED_W-INT_W-1){1'b0}}, rounded};
  end

endmodule

// File: rtl/fixed_coord_arbiter.sv
// Two-requester round-robin arbiter feeding one shared fixed-to-uint converter;
// x then y are converted on successive cycles and held until downstream accepts.
module fixed_coord_arbiter
  import gpu_fixed_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  input  logic [15:0] in0_x,
  input  logic [15:0] in0_y,
  input  logic        in1_valid,
  input  logic [15:0] in1_x,
  input  logic [15:0] in1_y,
  output logic        in0_ready,
  output logic        in1_ready,
  output logic        out_valid,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic        out_src,
  output logic        out_clamped,
  input  logic        out_ready
);

  localparam logic [FIXED_W-1:0] X_MAX = FIXED_W'(SCREEN_W - 1);
  localparam logic [FIXED_W-1:0] Y_MAX = FIXED_W'(SCREEN_H - 1);

  state_t             state, state_next;
  logic               grant, accept, last_grant, lat_src;
  logic [FIXED_W-1:0] lat_x, lat_y;
  logic [FIXED_W-1:0] conv_in, conv_out, bound, clamped_val;
  logic               over;

  fixed_to_uint u_conv (
    .fixed_in (conv_in),
    .uint_out (conv_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    accept     = 1'b0;
    in0_ready  = 1'b0;
    in1_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (in0_valid || in1_valid) begin
          // On a tie, the requester not served last wins.
          grant      = (in0_valid && in1_valid) ? ~last_grant : in1_valid;
          accept     = 1'b1;
          in0_ready  = ~grant;
          in1_ready  = grant;
          state_next = CONV_X;
        end
      end
      CONV_X:  state_next = CONV_Y;
      CONV_Y:  state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state == HOLD);

  always_comb begin
    conv_in     = (state == CONV_Y) ? lat_y : lat_x;
    bound       = (state == CONV_Y) ? Y_MAX : X_MAX;
    over        = (conv_out > bound);
    clamped_val = over ? bound : conv_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_x       <= '0;
      lat_y       <= '0;
      lat_src     <= 1'b0;
      last_grant  <= 1'b1;
      out_x       <= '0;
      out_y       <= '0;
      out_src     <= 1'b0;
      out_clamped <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_x      <= grant ? in1_x : in0_x;
            lat_y      <= grant ? in1_y : in0_y;
            lat_src    <= grant;
            last_grant <= grant;
          end
        end
        CONV_X: begin
          out_x       <= clamped_val;
          out_src     <= lat_src;
          out_clamped <= over;
        end
        CONV_Y: begin
          out_y       <= clamped_val;
          out_clamped <= out_clamped | over;
        end
        default: ;
      endcase
    end
  end

endmodule
